vram_arbiter: RTL and testbench

- Two-port front end that sits directly upstream of the 48K x 16 video RAM.
- Merges read requests from the display scan-out with read/write requests from the CPU bus, and issues one VRAM access per cycle.
- Routes each read result back to the port that requested it.
- Enforces the VRAM timing rule: read data is registered, and its bank mux follows the current address bits [15:14].

---
 rtl/vram_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// Two-port arbiter in front of the 48K x 16 banked video RAM: it merges display
// scan-out reads with CPU reads/writes, issues one access per cycle and routes read data back.
module vram_arbiter #(
    parameter int DISP_STREAK_MAX = 8,
    parameter int VRAM_WORDS      = 49152
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        disp_req_i,
    input  logic [15:0] disp_addr_i,
    output logic        disp_ack_o,
    output logic [15:0] disp_rdata_o,
    output logic        disp_rvalid_o,
    input  logic        cpu_valid_i,
    output logic        cpu_ready_o,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_mask_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [15:0] cpu_wdata_i,
    output logic [15:0] cpu_rdata_o,
    output logic        cpu_rvalid_o,
    output logic        vram_sel_o,
    output logic        vram_wr_en_o,
    output logic [3:0]  vram_wr_mask_o,
    output logic [15:0] vram_addr_o,
    output logic [15:0] vram_data_o,
    input  logic [15:0] vram_data_i
);

    localparam int STREAK_W = $clog2(DISP_STREAK_MAX + 1);

    // Tag travelling alongside a read so its data can be steered back to the requester.
    typedef struct packed {
        logic valid;
        logic cpu;
        logic oor;
    } rd_tag_t;

    logic [STREAK_W-1:0] streak;
    rd_tag_t             tag_s1;
    rd_tag_t             tag_s2;

    logic        disp_pri;
    logic        pick_disp;
    logic        pick_cpu;
    logic [15:0] cand_addr;
    logic        bank_block;
    logic        grant_disp;
    logic        grant_cpu;
    logic        grant_any;
    logic        grant_write;
    logic        cand_in_range;

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        disp_pri      = 1'b0;
        pick_disp     = 1'b0;
        pick_cpu      = 1'b0;
        cand_addr     = cpu_addr_i;
        bank_block    = 1'b0;
        grant_disp    = 1'b0;
        grant_cpu     = 1'b0;
        grant_any     = 1'b0;
        grant_write   = 1'b0;
        cand_in_range = 1'b0;

        disp_pri  = disp_req_i && (streak < STREAK_W'(DISP_STREAK_MAX));
        pick_disp = disp_pri || (disp_req_i && !cpu_valid_i);
        pick_cpu  = !disp_pri && cpu_valid_i;
        if (pick_disp) begin
            cand_addr = disp_addr_i;
        end
        cand_in_range = 32'(cand_addr) < VRAM_WORDS;

        // A read on the bus now has its data muxed next cycle by the address bits [15:14]
        // driven then, so the next command must stay in that bank or wait one cycle.
        bank_block = tag_s1.valid && (cand_addr[15:14] != vram_addr_o[15:14]);

        grant_disp  = pick_disp && !bank_block && !reset_i;
        grant_cpu   = pick_cpu && !bank_block && !reset_i;
        grant_any   = grant_disp || grant_cpu;
        grant_write = grant_cpu && cpu_we_i;
    end

    assign disp_ack_o  = grant_disp;
    assign cpu_ready_o = grant_cpu;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            streak         <= '0;
            tag_s1         <= '0;
            tag_s2         <= '0;
            vram_sel_o     <= 1'b0;
            vram_wr_en_o   <= 1'b0;
            vram_wr_mask_o <= '0;
            vram_addr_o    <= '0;
            vram_data_o    <= '0;
            disp_rvalid_o  <= 1'b0;
            disp_rdata_o   <= '0;
            cpu_rvalid_o   <= 1'b0;
            cpu_rdata_o    <= '0;
        end else begin
            if (!cpu_valid_i || grant_cpu) begin
                streak <= '0;
            end else if (grant_disp) begin
                streak <= streak + 1'b1;
            end

            if (grant_any) begin
                vram_sel_o     <= cand_in_range;
                vram_wr_en_o   <= grant_write;
                vram_wr_mask_o <= grant_write ? cpu_mask_i : 4'h0;
                vram_addr_o    <= cand_addr;
                vram_data_o    <= grant_write ? cpu_wdata_i : 16'h0000;
            end else begin
                // Idle or bubble: the address holds so the pending read's bank stays selected.
                vram_sel_o     <= 1'b0;
                vram_wr_en_o   <= 1'b0;
                vram_wr_mask_o <= 4'h0;
            end

            tag_s1 <= '{valid: grant_any && !grant_write, cpu: grant_cpu, oor: !cand_in_range};
            tag_s2 <= tag_s1;

            disp_rvalid_o <= tag_s2.valid && !tag_s2.cpu;
            cpu_rvalid_o  <= tag_s2.valid && tag_s2.cpu;
            if (tag_s2.valid) begin
                if (tag_s2.cpu) begin
                    cpu_rdata_o <= tag_s2.oor ? 16'h0000 : vram_data_i;
                end else begin
                    disp_rdata_o <= tag_s2.oor ? 16'h0000 : vram_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
// Directed bench for vram_arbiter with a banked VRAM model whose registered read data
// is muxed by the current address bank.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        disp_req_i;
    logic [15:0] disp_addr_i;
    logic        disp_ack_o;
    logic [15:0] disp_rdata_o;
    logic        disp_rvalid_o;
    logic        cpu_valid_i;
    logic        cpu_ready_o;
    logic        cpu_we_i;
    logic [3:0]  cpu_mask_i;
    logic [15:0] cpu_addr_i;
    logic [15:0] cpu_wdata_i;
    logic [15:0] cpu_rdata_o;
    logic        cpu_rvalid_o;
    logic        vram_sel_o;
    logic        vram_wr_en_o;
    logic [3:0]  vram_wr_mask_o;
    logic [15:0] vram_addr_o;
    logic [15:0] vram_data_o;
    logic [15:0] vram_data_i;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:49151];
    logic [15:0] bank_q [4];
    logic [15:0] disp_q [$];
    logic [15:0] d_list [$];
    logic        sel_hist [16];
    logic        post_sel;
    logic [15:0] post_addr;
    int          cpu_rv_cnt = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.DISP_STREAK_MAX(8), .VRAM_WORDS(49152)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .disp_req_i     (disp_req_i),
        .disp_addr_i    (disp_addr_i),
        .disp_ack_o     (disp_ack_o),
        .disp_rdata_o   (disp_rdata_o),
        .disp_rvalid_o  (disp_rvalid_o),
        .cpu_valid_i    (cpu_valid_i),
        .cpu_ready_o    (cpu_ready_o),
        .cpu_we_i       (cpu_we_i),
        .cpu_mask_i     (cpu_mask_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_wdata_i    (cpu_wdata_i),
        .cpu_rdata_o    (cpu_rdata_o),
        .cpu_rvalid_o   (cpu_rvalid_o),
        .vram_sel_o     (vram_sel_o),
        .vram_wr_en_o   (vram_wr_en_o),
        .vram_wr_mask_o (vram_wr_mask_o),
        .vram_addr_o    (vram_addr_o),
        .vram_data_o    (vram_data_o),
        .vram_data_i    (vram_data_i)
    );

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [3:0] mask);
        logic [15:0] r;
        r = old;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) r[4*n +: 4] = nw[4*n +: 4];
        end
        return r;
    endfunction

    // VRAM model: each bank registers the word it read; the output mux follows the live address.
    always @(posedge clk) begin
        if (vram_sel_o && vram_addr_o < 16'hC000) begin
            if (vram_wr_en_o) begin
                mem[vram_addr_o] <= merge(mem[vram_addr_o], vram_data_o, vram_wr_mask_o);
            end else begin
                bank_q[vram_addr_o[15:14]] <= mem[vram_addr_o];
            end
        end
    end
    assign vram_data_i = bank_q[vram_addr_o[15:14]];

    always @(negedge clk) begin
        if (disp_rvalid_o) disp_q.push_back(disp_rdata_o);
        if (cpu_rvalid_o) cpu_rv_cnt++;
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] all_outputs();
        return 80'({disp_ack_o, disp_rdata_o, disp_rvalid_o, cpu_ready_o, cpu_rdata_o,
                    cpu_rvalid_o, vram_sel_o, vram_wr_en_o, vram_wr_mask_o, vram_addr_o,
                    vram_data_o});
    endfunction

    task automatic cpu_xfer(input string tag, input logic we, input logic [15:0] addr,
                            input logic [3:0] mask, input logic [15:0] wdata,
                            input logic [15:0] exp);
        int t = 0;
        @(posedge clk); #1;
        cpu_valid_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr;
        cpu_mask_i = mask; cpu_wdata_i = wdata;
        @(negedge clk);
        while (!cpu_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_ready"}, 80'(cpu_ready_o), 80'(1));
        @(posedge clk); #1;
        cpu_valid_i = 1'b0; cpu_we_i = 1'b0;
        @(negedge clk);
        check({tag, "_sel"}, 80'(vram_sel_o), 80'(addr < 16'hC000));
        check({tag, "_wr_en"}, 80'(vram_wr_en_o), 80'(we));
        check({tag, "_rv_n1"}, 80'(cpu_rvalid_o), 80'(0));
        @(negedge clk);
        check({tag, "_rv_n2"}, 80'(cpu_rvalid_o), 80'(0));
        @(negedge clk);
        check({tag, "_rv_n3"}, 80'(cpu_rvalid_o), 80'(!we));
        if (!we) check({tag, "_rdata"}, 80'(cpu_rdata_o), 80'(exp));
    endtask

    task automatic disp_stream(input string tag, input int exp_cycles);
        int idx = 0;
        int t   = 0;
        disp_q.delete();
        @(posedge clk); #1;
        disp_req_i  = 1'b1;
        disp_addr_i = d_list[0];
        while (idx < d_list.size() && t < 50) begin
            @(negedge clk);
            if (t < 16) sel_hist[t] = vram_sel_o;
            t++;
            if (disp_ack_o) idx++;
            @(posedge clk); #1;
            if (idx < d_list.size()) disp_addr_i = d_list[idx];
            else disp_req_i = 1'b0;
        end
        disp_req_i = 1'b0;
        check({tag, "_cycles"}, 80'(t), 80'(exp_cycles));
        @(negedge clk);
        post_sel  = vram_sel_o;
        post_addr = vram_addr_o;
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_count"}, 80'(disp_q.size()), 80'(d_list.size()));
        for (int i = 0; i < d_list.size() && i < disp_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 80'(disp_q[i]), 80'(pat(d_list[i])));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 49152; i++) mem[i] = pat(16'(i));
        for (int b = 0; b < 4; b++) bank_q[b] = 16'h0000;
        reset_i = 1'b1; disp_req_i = 1'b0; disp_addr_i = 16'h0000;
        cpu_valid_i = 1'b0; cpu_we_i = 1'b0; cpu_mask_i = 4'h0;
        cpu_addr_i = 16'h0000; cpu_wdata_i = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 80'(0));
        @(posedge clk); #1;
        reset_i = 1'b0;

        // CPU write, readback, partial-mask write, readback
        cpu_xfer("wr_full", 1'b1, 16'h0100, 4'hF, 16'h1234, 16'h0000);
        cpu_xfer("rd_full", 1'b0, 16'h0100, 4'h0, 16'h0000, 16'h1234);
        cpu_xfer("wr_mask", 1'b1, 16'h0100, 4'h3, 16'hABCD, 16'h0000);
        cpu_xfer("rd_mask", 1'b0, 16'h0100, 4'h0, 16'h0000, 16'h12CD);

        // Same-bank display stream: one ack per cycle
        d_list.delete();
        for (int i = 0; i < 8; i++) d_list.push_back(16'(i));
        disp_stream("stream", 8);
        check("stream_post_sel", 80'(post_sel), 80'(1));
        check("stream_post_addr", 80'(post_addr), 80'(16'h0007));

        // Bank crossing: one bubble between 0x3FFF and 0x4000
        d_list.delete();
        d_list.push_back(16'h3FFF);
        d_list.push_back(16'h4000);
        disp_stream("bank", 3);
        check("bank_sel_cmd0", 80'(sel_hist[1]), 80'(1));
        check("bank_sel_bubble", 80'(sel_hist[2]), 80'(0));
        check("bank_post_sel", 80'(post_sel), 80'(1));
        check("bank_post_addr", 80'(post_addr), 80'(16'h4000));

        // Starvation guard: 8 display grants, then 1 CPU grant, repeating
        @(posedge clk); #1;
        disp_req_i = 1'b1; disp_addr_i = 16'h0010;
        cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0020;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            check($sformatf("starve_%0d", i), 80'({disp_ack_o, cpu_ready_o}),
                  80'((i % 9 == 8) ? 2'b01 : 2'b10));
        end
        @(posedge clk); #1;
        disp_req_i = 1'b0; cpu_valid_i = 1'b0;
        repeat (5) @(posedge clk);

        // Out-of-range write is suppressed, read returns zero
        cpu_xfer("oor_wr", 1'b1, 16'hC000, 4'hF, 16'hFFFF, 16'h0000);
        cpu_xfer("oor_rd", 1'b0, 16'hC000, 4'h0, 16'h0000, 16'h0000);

        // Reset one cycle after a read is accepted drops the response
        @(posedge clk); #1;
        cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0100;
        begin
            int t = 0;
            @(negedge clk);
            while (!cpu_ready_o && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("rst_rd_ready", 80'(cpu_ready_o), 80'(1));
        end
        @(posedge clk); #1;
        cpu_valid_i = 1'b0;
        reset_i     = 1'b1;
        cpu_rv_cnt  = 0;
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", all_outputs(), 80'(0));
        repeat (4) @(negedge clk);
        check("rst_mid_no_rvalid", 80'(cpu_rv_cnt), 80'(0));
        cpu_xfer("rd_after_rst", 1'b0, 16'h0100, 4'h0, 16'h0000, 16'h12CD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
